// File: rtl/naive_bus_uart_tx_slave_if.sv
// naive_bus data-bus interface: grant-based read channel and write channel.
interface naive_bus;
  logic        rd_req;
  logic        rd_gnt;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        wr_req;
  logic        wr_gnt;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
    input  rd_gnt, rd_data, wr_gnt
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
    output rd_gnt, rd_data, wr_gnt
  );
endinterface

// File: rtl/naive_bus_uart_tx_slave.sv
// naive_bus slave driving a UART TX line through a byte FIFO, with STATUS and DIV registers.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1 framing, STATUS bit3 set).
module naive_bus_uart_tx_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          FIFO_AW     = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic    clk,
  input  logic    rstn,
  naive_bus.slave bus,
  output logic    o_uart_tx
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   DEPTH_CNT = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  logic               rd_hit, wr_hit, wr_is_tx, wr_gnt_int;
  logic [1:0]         rd_off, wr_off;
  logic               fifo_full, fifo_empty, push, frame_load;
  logic [FIFO_AW:0]   count_reg, count_next;
  logic [FIFO_AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [7:0]         fifo_mem [DEPTH];
  logic [7:0]         head_byte;
  logic [15:0]        div_reg, div_eff;
  logic [31:0]        rd_data_reg, rd_data_next, status;
  state_t             state_reg;
  logic [7:0]         shift_reg;
  logic [15:0]        bit_len_reg, bit_cnt_reg;
  logic [2:0]         bit_idx_reg;
  logic               tx_reg, bit_end;
`ifdef UART_TX_PARITY_EN
  logic               parity_reg;
`endif
  logic               unused_bits;

  assign unused_bits = ^{bus.wr_data[31:16], bus.wr_be[3:2], bus.rd_addr[1:0], bus.wr_addr[1:0]};

  assign rd_hit   = bus.rd_addr[31:4] == BASE_ADDR[31:4];
  assign wr_hit   = bus.wr_addr[31:4] == BASE_ADDR[31:4];
  assign rd_off   = bus.rd_addr[3:2];
  assign wr_off   = bus.wr_addr[3:2];
  assign wr_is_tx = wr_off == 2'd0;

  assign fifo_full  = count_reg == DEPTH_CNT;
  assign fifo_empty = count_reg == '0;

  // A TXDATA store into a full FIFO is stalled by withholding the grant.
  assign wr_gnt_int  = bus.wr_req & wr_hit & ~(wr_is_tx & fifo_full);
  assign bus.wr_gnt  = wr_gnt_int;
  assign bus.rd_gnt  = bus.rd_req & rd_hit;
  assign bus.rd_data = rd_data_reg;
  assign o_uart_tx   = tx_reg;

  assign push    = wr_gnt_int & wr_is_tx & bus.wr_be[0];
  assign bit_end = bit_cnt_reg == 16'd0;
  // The next frame is loaded from IDLE or straight out of the last STOP cycle so frames abut.
  assign frame_load = ~fifo_empty & ((state_reg == S_IDLE) | ((state_reg == S_STOP) & bit_end));
  assign head_byte  = fifo_mem[rd_ptr_reg];
  assign div_eff    = (div_reg == 16'd0) ? 16'd1 : div_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_div_byte
    logic [7:0] byte_reg;
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        byte_reg <= DEFAULT_DIV[gi*8 +: 8];
      end else if (wr_gnt_int && wr_off == 2'd2 && bus.wr_be[gi]) begin
        byte_reg <= bus.wr_data[gi*8 +: 8];
      end
    end
    assign div_reg[gi*8 +: 8] = byte_reg;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= bus.wr_data[7:0];
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, frame_load})
      2'b10:   count_next = count_reg + CNT_ONE;
      2'b01:   count_next = count_reg - CNT_ONE;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      count_reg <= count_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (frame_load) rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

  always_comb begin
    status = '0;
    status[0] = fifo_full;
    status[1] = fifo_empty;
    status[2] = state_reg != S_IDLE;
`ifdef UART_TX_PARITY_EN
    status[3] = 1'b1;
`endif
    status[8 +: FIFO_AW + 1] = count_reg;
    case (rd_off)
      2'd1:    rd_data_next = status;
      2'd2:    rd_data_next = {16'd0, div_reg};
      default: rd_data_next = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data_reg <= 32'd0;
    end else if (bus.rd_gnt) begin
      rd_data_reg <= rd_data_next;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= S_IDLE;
      shift_reg   <= 8'd0;
      bit_len_reg <= 16'd1;
      bit_cnt_reg <= 16'd0;
      bit_idx_reg <= 3'd0;
      tx_reg      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_reg  <= 1'b0;
`endif
    end else if (frame_load) begin
      shift_reg   <= head_byte;
      bit_len_reg <= div_eff;
      bit_cnt_reg <= div_eff - 16'd1;
      tx_reg      <= 1'b0;
      state_reg   <= S_START;
`ifdef UART_TX_PARITY_EN
      parity_reg  <= ^head_byte;
`endif
    end else if (state_reg != S_IDLE) begin
      if (!bit_end) begin
        bit_cnt_reg <= bit_cnt_reg - 16'd1;
      end else begin
        bit_cnt_reg <= bit_len_reg - 16'd1;
        case (state_reg)
          S_START: begin
            state_reg   <= S_DATA;
            tx_reg      <= shift_reg[0];
            bit_idx_reg <= 3'd0;
          end
          S_DATA: begin
            if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_reg <= S_PARITY;
              tx_reg    <= parity_reg;
`else
              state_reg <= S_STOP;
              tx_reg    <= 1'b1;
`endif
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
              shift_reg   <= {1'b0, shift_reg[7:1]};
              tx_reg      <= shift_reg[1];
            end
          end
`ifdef UART_TX_PARITY_EN
          S_PARITY: begin
            state_reg <= S_STOP;
            tx_reg    <= 1'b1;
          end
`endif
          default: begin
            state_reg <= S_IDLE;
            tx_reg    <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_naive_bus_uart_tx_slave.sv
// Directed + randomized bench for naive_bus_uart_tx_slave; a frame-level line model checks every bit.
module tb_naive_bus_uart_tx_slave;
  localparam logic [31:0] BASE = 32'h1000_0000;
`ifdef UART_TX_PARITY_EN
  localparam int          NBITS    = 11;
  localparam logic [31:0] PAR_FLAG = 32'h0000_0008;
`else
  localparam int          NBITS    = 10;
  localparam logic [31:0] PAR_FLAG = 32'h0000_0000;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic uart_tx;
  naive_bus bus_i ();

  naive_bus_uart_tx_slave #(
    .BASE_ADDR(BASE), .FIFO_AW(4), .DEFAULT_DIV(16'd868)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus_i), .o_uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail = 0;
  logic [7:0]  exp_q [$];
  logic [15:0] model_div = 16'd868;
  int          frames_done = 0;
  int          frames_exp = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] status_model(input bit busy, input int cnt);
    return 32'(cnt * 256 + (busy ? 4 : 0) + (cnt == 0 ? 2 : 0) + (cnt == 16 ? 1 : 0)) | PAR_FLAG;
  endfunction

  task automatic rd_check(input string tag, input logic [31:0] addr, input logic exp_gnt,
                          input logic [31:0] exp_data);
    @(posedge clk); #1;
    bus_i.rd_req = 1'b1;
    bus_i.rd_addr = addr;
    @(negedge clk);
    chk({tag, "_gnt"}, 32'(bus_i.rd_gnt), 32'(exp_gnt));
    @(posedge clk); #1;
    bus_i.rd_req = 1'b0;
    @(negedge clk);
    chk({tag, "_data"}, bus_i.rd_data, exp_data);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be,
                          input int max_wait, output bit granted, output int waited);
    logic [31:0] a;
    a = addr;
    @(posedge clk); #1;
    bus_i.wr_req = 1'b1;
    bus_i.wr_addr = addr;
    bus_i.wr_data = data;
    bus_i.wr_be = be;
    granted = 1'b0;
    waited = 0;
    while (!granted && waited < max_wait) begin
      @(negedge clk);
      if (bus_i.wr_gnt === 1'b1) granted = 1'b1;
      else waited++;
    end
    @(posedge clk);
    if (granted) begin
      if (a[3:2] == 2'd0 && be[0]) begin
        exp_q.push_back(data[7:0]);
        frames_exp++;
      end
      if (a[3:2] == 2'd2) begin
        if (be[0]) model_div[7:0] = data[7:0];
        if (be[1]) model_div[15:8] = data[15:8];
      end
    end
    #1 bus_i.wr_req = 1'b0;
  endtask

  task automatic wr_ok(input string tag, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] be);
    bit g;
    int w;
    do_write(addr, data, be, 20, g, w);
    chk(tag, 32'(g), 32'd1);
  endtask

  task automatic wait_frames(input int bound);
    int w;
    w = 0;
    while (frames_done < frames_exp && w < bound) begin
      @(negedge clk);
      w++;
    end
    chk("frames_done", frames_done, frames_exp);
  endtask

  // Line monitor: every frame must be start, 8 data bits LSB first, [parity], stop, each bit_len cycles.
  initial begin : monitor
    logic [7:0] b;
    logic       bits [NBITS];
    int         len, end_cyc, bad;
    bit         pending, aborted;
    pending = 1'b0;
    end_cyc = 0;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && uart_tx === 1'b0) begin
        len = (model_div == 16'd0) ? 1 : int'(model_div);
        if (pending) chk("b2b_no_gap", cyc, end_cyc + 1);
        chk("frame_expected", 32'(exp_q.size()), (exp_q.size() > 0) ? 32'(exp_q.size()) : 32'd1);
        if (exp_q.size() > 0) b = exp_q.pop_front();
        else b = 8'h00;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i + 1] = (b >> i) & 8'd1;
`ifdef UART_TX_PARITY_EN
        bits[9] = ($countones(b) % 2) == 1;
`endif
        bits[NBITS - 1] = 1'b1;
        aborted = 1'b0;
        for (int k = 0; k < NBITS && !aborted; k++) begin
          bad = 0;
          for (int c = 0; c < len; c++) begin
            if (k != 0 || c != 0) @(negedge clk);
            if (rstn !== 1'b1) begin
              aborted = 1'b1;
              break;
            end
            if (uart_tx !== bits[k]) bad++;
          end
          if (!aborted) chk($sformatf("byte_%02h_bit%0d_bad_cycles", b, k), bad, 0);
        end
        pending = !aborted && exp_q.size() > 0;
        end_cyc = cyc;
        if (!aborted) frames_done++;
      end
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit g;
    int w, base;
    logic [7:0] rb;
    logic [3:0] rbe;
    bus_i.rd_req = 1'b0; bus_i.rd_addr = '0;
    bus_i.wr_req = 1'b0; bus_i.wr_addr = '0; bus_i.wr_data = '0; bus_i.wr_be = '0;

    repeat (3) @(posedge clk);
    #1 chk("reset_tx_idle", 32'(uart_tx), 32'd1);
    @(posedge clk); #1 rstn = 1'b1;

    rd_check("reset_div", BASE + 32'h8, 1'b1, 32'h0000_0364);
    rd_check("reset_status", BASE + 32'h4, 1'b1, status_model(0, 0));
    chk("idle_tx", 32'(uart_tx), 32'd1);

    // Single frame at DIV=4
    wr_ok("wr_div4", BASE + 32'h8, 32'd4, 4'h3);
    wr_ok("wr_tx_a5", BASE, 32'h0000_00A5, 4'h1);
    rd_check("status_busy", BASE + 32'h4, 1'b1, status_model(1, 0));
    wait_frames(200);
    rd_check("status_after_a5", BASE + 32'h4, 1'b1, status_model(0, 0));

    // Decode, reserved, byte enables
    do_write(BASE + 32'h10, 32'h55, 4'hF, 50, g, w);
    chk("miss_wr_no_gnt", 32'(g), 32'd0);
    wr_ok("wr_reserved", BASE + 32'hC, 32'hFFFF_FFFF, 4'hF);
    rd_check("rd_reserved", BASE + 32'hC, 1'b1, 32'd0);
    rd_check("rd_txdata", BASE, 1'b1, 32'd0);
    rd_check("div_unchanged", BASE + 32'h8, 1'b1, {16'd0, model_div});
    rd_check("miss_rd_hold", BASE + 32'h14, 1'b0, {16'd0, model_div});
    wr_ok("wr_div_be1", BASE + 32'h8, 32'h0000_AB77, 4'h2);
    rd_check("div_be1", BASE + 32'h8, 1'b1, {16'd0, model_div});
    wr_ok("wr_tx_be0_off", BASE, 32'h0000_0033, 4'hE);
    rd_check("status_no_push", BASE + 32'h4, 1'b1, status_model(0, 0));

    // Divisor 0 acts as 1; a DIV write mid-frame only affects the next frame
    wr_ok("wr_div0", BASE + 32'h8, 32'd0, 4'h3);
    wr_ok("wr_tx_ff", BASE, 32'h0000_00FF, 4'h1);
    wr_ok("wr_tx_3c", BASE, 32'h0000_003C, 4'h1);
    wr_ok("wr_div8_mid", BASE + 32'h8, 32'd8, 4'h3);
    wait_frames(500);
    rd_check("div8", BASE + 32'h8, 1'b1, 32'd8);

    // Randomized divisors, bytes and byte enables
    for (int it = 0; it < 4; it++) begin
      wr_ok("wr_div_rand", BASE + 32'h8, 32'($urandom_range(1, 5)), 4'h3);
      for (int n = 0; n < int'($urandom_range(1, 3)); n++) begin
        rb = 8'($urandom);
        rbe = 4'($urandom);
        wr_ok("wr_tx_rand", BASE, {24'd0, rb}, rbe);
      end
      wait_frames(1000);
      rd_check("status_rand_idle", BASE + 32'h4, 1'b1, status_model(0, 0));
    end

    // Parity frame (plain 8N1 without the parity build)
    wr_ok("wr_div2", BASE + 32'h8, 32'd2, 4'h3);
    wr_ok("wr_tx_07", BASE, 32'h0000_0007, 4'h1);
    wait_frames(200);
    rd_check("status_flag", BASE + 32'h4, 1'b1, status_model(0, 0));

    // Backpressure: 17 writes without stall, the 18th waits for the first frame to end
    wr_ok("wr_div100", BASE + 32'h8, 32'd100, 4'h3);
    base = frames_done;
    for (int i = 0; i < 17; i++) begin
      do_write(BASE, 32'(i), 4'h1, 20, g, w);
      chk($sformatf("bp_wr%0d_stall_cycles", i), w, 0);
    end
    rd_check("status_full", BASE + 32'h4, 1'b1, status_model(1, 16));
    do_write(BASE, 32'h11, 4'h1, 3000, g, w);
    chk("bp_wr17_granted", 32'(g), 32'd1);
    chk("bp_wr17_stalled", 32'(w > 900), 32'd1);
    chk("bp_frames_at_grant", frames_done - base, 1);
    wait_frames(25000);
    rd_check("status_bp_done", BASE + 32'h4, 1'b1, status_model(0, 0));

    // Asynchronous reset mid-frame
    wr_ok("wr_div20", BASE + 32'h8, 32'd20, 4'h3);
    wr_ok("wr_tx_00a", BASE, 32'h0, 4'h1);
    wr_ok("wr_tx_00b", BASE, 32'h0, 4'h1);
    repeat (40) @(negedge clk);
    chk("pre_reset_tx_low", 32'(uart_tx), 32'd0);
    @(posedge clk); #2 rstn = 1'b0;
    #1 chk("async_reset_tx", 32'(uart_tx), 32'd1);
    exp_q.delete();
    frames_exp = frames_done;
    model_div = 16'd868;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    rd_check("status_after_reset", BASE + 32'h4, 1'b1, status_model(0, 0));
    rd_check("div_after_reset", BASE + 32'h8, 1'b1, 32'h0000_0364);
    repeat (30) @(negedge clk);
    chk("no_frame_after_reset", frames_done, frames_exp);
    chk("tx_idle_after_reset", 32'(uart_tx), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
